// File: rtl/program_loader_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader_ctrl
//  Description : Writes a program image into the CPU's RAM over the shared
//                bus. Each byte is accepted from a valid/ready source, then
//                placed on the bus in order: MAR address load, MAR data load,
//                RAM write strobe. The CPU is held while the loader owns the
//                bus.
//                Optional build macro: LOADER_CHECKSUM_EN enables a mod-256
//                running checksum of the accepted bytes.
//  Revision    : 1.0  initial release
// ============================================================================
module program_loader_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int RAM_BYTES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              data_last,
  output logic              data_ready,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              nLma,
  output logic              nLmd,
  output logic              nCE,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   byte_count,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_ADDR  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  // Highest RAM location; writing it ends the load even without data_last.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);

  state_t              state;
  state_t              next_state;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   held_byte;
  logic                held_last;
  logic                accept;
  logic                final_byte;

  // A byte transfers only while waiting for one; data_ready is tied to WAIT.
  assign accept     = (state == S_WAIT) && data_valid;
  assign final_byte = held_last || (addr == LAST_ADDR);

  // State register; reset returns to IDLE from any state, mid-write included.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and per-state bus/strobe outputs.
  always_comb begin
    next_state = state;
    data_ready = 1'b0;
    bus_out    = '0;
    bus_oe     = 1'b0;
    nLma       = 1'b1;
    nLmd       = 1'b1;
    nCE        = 1'b1;
    cpu_hold   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        data_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (data_valid) begin
          next_state = S_ADDR;
        end
      end
      S_ADDR: begin
        cpu_hold   = 1'b1;
        bus_oe     = 1'b1;
        bus_out    = DATA_W'(addr);
        nLma       = 1'b0;
        next_state = S_DATA;
      end
      S_DATA: begin
        cpu_hold   = 1'b1;
        bus_oe     = 1'b1;
        bus_out    = held_byte;
        nLmd       = 1'b0;
        next_state = S_WRITE;
      end
      S_WRITE: begin
        cpu_hold   = 1'b1;
        nCE        = 1'b0;
        next_state = final_byte ? S_FIN : S_WAIT;
      end
      S_FIN: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Address, byte counter and captured byte/last flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= '0;
      byte_count <= '0;
      held_byte  <= '0;
      held_last  <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start) begin
        addr       <= '0;
        byte_count <= '0;
      end
      if (accept) begin
        held_byte <= data_in;
        held_last <= data_last;
      end
      if (state == S_WRITE) begin
        byte_count <= byte_count + (ADDR_W+1)'(1);
        if (!final_byte) begin
          addr <= addr + ADDR_W'(1);
        end
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;

  // Mod-256 sum of accepted bytes; cleared on start, held after FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
    end else if ((state == S_IDLE) && start) begin
      sum <= '0;
    end else if (accept) begin
      sum <= sum + data_in;
    end
  end

  assign checksum = sum;
`else
  assign checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_program_loader_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_loader_ctrl
//  Description : Self-checking bench for program_loader_ctrl. A bus-side RAM
//                and MAR model records what the loader writes; expectations
//                come from the load rules (byte i lands at address i, at most
//                RAM_BYTES bytes, data_last ends the load early).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_program_loader_ctrl;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int RAM_BYTES = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_last;
  logic              data_ready;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic              nLma;
  logic              nLmd;
  logic              nCE;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   byte_count;
  logic [DATA_W-1:0] checksum;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  program_loader_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RAM_BYTES(RAM_BYTES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_last (data_last),
    .data_ready(data_ready),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .nLma      (nLma),
    .nLmd      (nLmd),
    .nCE       (nCE),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .byte_count(byte_count),
    .checksum  (checksum)
  );

  // Bus-side model of the MAR and RAM that the loader writes into.
  logic [ADDR_W-1:0] mar_a;
  logic [DATA_W-1:0] mar_d;
  logic [DATA_W-1:0] ram [RAM_BYTES];
  logic              ram_clear = 1'b0;

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < RAM_BYTES; i++) ram[i] <= 8'hEE;
    end else begin
      if (!nLma) mar_a <= bus_out[ADDR_W-1:0];
      if (!nLmd) mar_d <= bus_out;
      if (!nCE)  ram[mar_a] <= mar_d;
    end
  end

  // Observations from the most recent load: strobe events {kind, bus value}
  // with kind 1=address load, 2=data load, 3=RAM write.
  logic [9:0] obs_ev[$];
  int         obs_bad;
  int         obs_done_cyc;
  int         obs_acc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ram();
    ram_clear = 1'b1;
    tick();
    ram_clear = 1'b0;
  endtask

  // Drives one load: pulses start, offers bytes (random idle gaps of gap_pct
  // percent), optionally pulses start again on cycle ign_cyc, and records the
  // bus activity until done or max_cyc cycles. Returns in the done cycle.
  task automatic run_load(input logic [7:0] b[$], input bit use_last,
                          input int gap_pct, input int ign_cyc, input int max_cyc);
    int idx  = 0;
    int cyc  = 1;
    bit pend = 1'b0;
    obs_ev.delete();
    obs_bad      = 0;
    obs_done_cyc = -1;
    start        = 1'b1;
    data_valid   = 1'b0;
    data_last    = 1'b0;
    tick();
    start = 1'b0;
    while (cyc < max_cyc) begin
      if ((int'(!nLma) + int'(!nLmd) + int'(!nCE)) > 1) obs_bad++;
      if (bus_oe !== (!nLma || !nLmd)) obs_bad++;
      if (!nLma) obs_ev.push_back({2'd1, bus_out});
      if (!nLmd) obs_ev.push_back({2'd2, bus_out});
      if (!nCE)  obs_ev.push_back({2'd3, 8'h00});
      if (done) begin
        obs_done_cyc = cyc;
        break;
      end
      start = (cyc == ign_cyc);
      if (!pend && idx < b.size() && $urandom_range(99) >= gap_pct) pend = 1'b1;
      data_valid = pend;
      data_in    = pend ? b[idx] : 8'($urandom);
      data_last  = pend && use_last && (idx == b.size() - 1);
      if (pend && data_ready) begin
        idx++;
        pend = 1'b0;
      end
      tick();
      cyc++;
    end
    start   = 1'b0;
    obs_acc = idx;
  endtask

  // Reference: number of bytes a load of b writes (-1: load never ends).
  function automatic int model_len(input logic [7:0] b[$], input bit use_last);
    if (b.size() >= RAM_BYTES) return RAM_BYTES;
    return use_last ? b.size() : -1;
  endfunction

  // Reference: expected bus events for the first n bytes of b.
  function automatic void model_events(input logic [7:0] b[$], input int n,
                                       output logic [9:0] ev[$]);
    ev.delete();
    for (int i = 0; i < n; i++) begin
      ev.push_back({2'd1, 8'(i)});
      ev.push_back({2'd2, b[i]});
      ev.push_back({2'd3, 8'h00});
    end
  endfunction

  // Reference: checksum output after loading the first n bytes of b.
  function automatic logic [7:0] model_sum(input logic [7:0] b[$], input int n);
    int s = 0;
`ifdef LOADER_CHECKSUM_EN
    for (int i = 0; i < n; i++) s += int'(b[i]);
`endif
    return 8'(s % 256);
  endfunction

  // Index of first difference between two event lists, -1 when equal.
  function automatic int first_diff(input logic [9:0] a[$], input logic [9:0] e[$]);
    int m = (a.size() < e.size()) ? a.size() : e.size();
    for (int i = 0; i < m; i++) if (a[i] !== e[i]) return i;
    return (a.size() == e.size()) ? -1 : m;
  endfunction

  task automatic test_reset();
    logic [14:0] got;
    rst = 1'b1; start = 1'b0; data_valid = 1'b0; data_last = 1'b0; data_in = 8'h00;
    tick();
    tick();
    got = {nLma, nLmd, nCE, bus_oe, cpu_hold, busy, done, data_ready, byte_count, bus_out == 8'h00};
    n_checks++;
    if (got !== {3'b111, 5'b00000, 5'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required %b", got, {3'b111, 5'b00000, 5'd0, 1'b1});
    end
    n_checks++;
    if (checksum !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_checksum: got %h required 00", checksum);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_three_byte();
    logic [7:0] b[$] = '{8'h1A, 8'h2B, 8'h3C};
    logic [9:0] ev[$];
    int d;
    clear_ram();
    run_load(b, 1'b1, 0, 0, 100);
    model_events(b, 3, ev);
    d = first_diff(obs_ev, ev);
    n_checks++;
    if (obs_done_cyc != 13) begin
      n_fail++;
      $display("FAIL three_done_cycle: got %0d required 13", obs_done_cyc);
    end
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL three_strobe_order: first difference at event %0d (%0d seen, %0d required)",
               d, obs_ev.size(), ev.size());
    end
    n_checks++;
    if (byte_count !== 5'd3 || checksum !== model_sum(b, 3) || obs_bad != 0) begin
      n_fail++;
      $display("FAIL three_count_sum: count %0d sum %h bad %0d required 3 %h 0",
               byte_count, checksum, obs_bad, model_sum(b, 3));
    end
    data_valid = 1'b0; data_last = 1'b0;
    tick();
    n_checks++;
    if ({ram[0], ram[1], ram[2], ram[3]} !== {8'h1A, 8'h2B, 8'h3C, 8'hEE} || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL three_ram: got %h %h %h %h busy %b required 1a 2b 3c ee busy 0",
               ram[0], ram[1], ram[2], ram[3], busy);
    end
  endtask

  task automatic test_full_image();
    logic [7:0] b[$];
    int bad = 0;
    for (int i = 0; i <= RAM_BYTES; i++) b.push_back(8'(i));
    clear_ram();
    run_load(b, 1'b0, 0, 0, 200);
    n_checks++;
    if (obs_done_cyc != 4 * RAM_BYTES + 1 || obs_acc != RAM_BYTES) begin
      n_fail++;
      $display("FAIL full_done: cycle %0d accepted %0d required %0d %0d",
               obs_done_cyc, obs_acc, 4 * RAM_BYTES + 1, RAM_BYTES);
    end
    n_checks++;
    if (byte_count !== 5'(RAM_BYTES) || checksum !== model_sum(b, RAM_BYTES)) begin
      n_fail++;
      $display("FAIL full_count_sum: count %0d sum %h required %0d %h",
               byte_count, checksum, RAM_BYTES, model_sum(b, RAM_BYTES));
    end
    for (int c = 0; c < 4; c++) begin
      if (data_ready !== 1'b0 || (c > 0 && busy !== 1'b0)) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL full_17th_refused: %0d cycles offered ready/busy, required 0", bad);
    end
    data_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < RAM_BYTES; i++) if (ram[i] !== 8'(i)) bad++;
    n_checks++;
    if (bad != 0 || byte_count !== 5'(RAM_BYTES)) begin
      n_fail++;
      $display("FAIL full_ram: %0d wrong locations, count %0d", bad, byte_count);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    int w = 0;
    clear_ram();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if ({data_ready, nLma, nLmd, nCE, bus_oe, busy, cpu_hold} !== 7'b1111011) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_wait_hold: %0d of 5 idle cycles left WAIT behaviour", bad);
    end
    data_valid = 1'b1; data_in = 8'h55; data_last = 1'b1;
    tick();
    data_valid = 1'b0; data_last = 1'b0;
    n_checks++;
    if ({nLma, bus_oe, bus_out} !== {1'b0, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL bp_addr_phase: nLma %b oe %b bus %h required 0 1 00", nLma, bus_oe, bus_out);
    end
    while (!done && w < 10) begin
      tick();
      w++;
    end
    tick();
    n_checks++;
    if (ram[0] !== 8'h55 || byte_count !== 5'd1 || w >= 10) begin
      n_fail++;
      $display("FAIL bp_result: ram0 %h count %0d waited %0d required 55 1", ram[0], byte_count, w);
    end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    int writes = 0;
    clear_ram();
    start = 1'b1; data_valid = 1'b1; data_in = 8'h77; data_last = 1'b0;
    tick();
    start = 1'b0;
    while (nLmd !== 1'b0 && w < 10) begin
      tick();
      w++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; data_valid = 1'b0;
    n_checks++;
    if (w >= 10 || {nLmd, nCE, bus_oe, cpu_hold, busy, byte_count} !== {2'b11, 3'b000, 5'd0}) begin
      n_fail++;
      $display("FAIL rst_mid: reached %0d nLmd %b nCE %b oe %b hold %b busy %b count %0d",
               w, nLmd, nCE, bus_oe, cpu_hold, busy, byte_count);
    end
    for (int c = 0; c < 4; c++) begin
      if (nCE !== 1'b1) writes++;
      tick();
    end
    n_checks++;
    if (writes != 0 || ram[0] !== 8'hEE) begin
      n_fail++;
      $display("FAIL rst_mid_no_write: %0d write strobes, ram0 %h required 0 ee", writes, ram[0]);
    end
  endtask

  task automatic test_ignored_start();
    logic [7:0] b[$] = '{8'hC3, 8'h5A, 8'h0F, 8'hF0};
    logic [9:0] ev[$];
    int d;
    clear_ram();
    run_load(b, 1'b1, 0, 5, 100);
    model_events(b, 4, ev);
    d = first_diff(obs_ev, ev);
    n_checks++;
    if (d != -1 || obs_done_cyc != 17 || byte_count !== 5'd4) begin
      n_fail++;
      $display("FAIL ignored_start: diff at %0d done %0d count %0d required -1 17 4",
               d, obs_done_cyc, byte_count);
    end
    data_valid = 1'b0; data_last = 1'b0;
    tick();
  endtask

  task automatic test_start_with_valid();
    int w = 0;
    start = 1'b1; data_valid = 1'b1; data_in = 8'hA5; data_last = 1'b1;
    n_checks++;
    if (data_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ready: got %b required 0", data_ready);
    end
    tick();
    start = 1'b0;
    tick();
    data_valid = 1'b0; data_last = 1'b0;
    while (!done && w < 10) begin
      tick();
      w++;
    end
    n_checks++;
    if (w >= 10 || byte_count !== 5'd1) begin
      n_fail++;
      $display("FAIL start_valid_count: count %0d waited %0d required 1", byte_count, w);
    end
    tick();
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      logic [7:0] b[$];
      logic [9:0] ev[$];
      int  sz  = $urandom_range(1, 20);
      bit  ul  = (sz < RAM_BYTES) ? 1'b1 : 1'($urandom_range(1));
      int  n;
      int  d;
      int  bad = 0;
      for (int i = 0; i < sz; i++) b.push_back(8'($urandom));
      n = model_len(b, ul);
      clear_ram();
      run_load(b, ul, 40, 0, 2000);
      model_events(b, n, ev);
      d = first_diff(obs_ev, ev);
      for (int i = 0; i < RAM_BYTES; i++)
        if (ram[i] !== ((i < n) ? b[i] : 8'hEE) && i >= n) bad++;
      data_valid = 1'b0; data_last = 1'b0;
      tick();
      for (int i = 0; i < n; i++) if (ram[i] !== b[i]) bad++;
      n_checks++;
      if (obs_done_cyc < 0 || d != -1 || obs_bad != 0 || bad != 0 ||
          byte_count !== 5'(n) || checksum !== model_sum(b, n)) begin
        n_fail++;
        $display("FAIL random_load %0d: size %0d done %0d diff %0d proto %0d ram %0d count %0d sum %h required count %0d sum %h",
                 t, sz, obs_done_cyc, d, obs_bad, bad, byte_count, checksum, n, model_sum(b, n));
      end
    end
  endtask

  initial begin
    test_reset();
    test_three_byte();
    test_full_image();
    test_backpressure();
    test_reset_mid();
    test_ignored_start();
    test_start_with_valid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/program_loader_ctrl.md
Name: program_loader_ctrl

Overview:
- Sequencer that writes a program image into the CPU's 16-byte RAM through the shared 8-bit bus and the input/MAR register, before or between CPU runs.
- Accepts bytes from an external valid/ready source (driven from ui_in), then drives the MAR-address load, MAR-data load and RAM write strobes in order.
- Holds the CPU control block and program counter in hold while it owns the bus.

Parameters:
- ADDR_W, 4, RAM address width; MAR address is the low ADDR_W bits of the bus.
- DATA_W, 8, bus and byte width.
- RAM_BYTES, 16, number of RAM locations; must be at most 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse that begins a load at address 0.
- data_in  in  DATA_W  byte from the external source.
- data_valid  in  1  data_in is valid.
- data_last  in  1  qualifies data_in as the final byte, sampled with data_valid.
- data_ready  out  1  loader can accept a byte this cycle.
- bus_out  out  DATA_W  value the loader drives onto the bus.
- bus_oe  out  1  tri-state enable for bus_out.
- nLma  out  1  active-low MAR address load.
- nLmd  out  1  active-low MAR data load.
- nCE  out  1  active-low RAM write strobe.
- cpu_hold  out  1  high while the loader owns the bus; CPU control and PC are frozen.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a load completes.
- byte_count  out  ADDR_W+1  number of bytes written in the current or last load.
- checksum  out  DATA_W  running checksum; see Optional Feature.

Behaviour:
- Reset values: nLma=nLmd=nCE=1, bus_oe=0, bus_out=0, data_ready=0, cpu_hold=0, busy=0, done=0, byte_count=0, checksum=0, internal addr=0, state=IDLE.
- Reset taken in any state, mid-write included, returns to IDLE on the next edge. A partially written RAM is left as-is.
- States: IDLE, WAIT, ADDR, DATA, WRITE, FIN.
- IDLE:
  - start=1 -> WAIT; addr:=0, byte_count:=0, checksum:=0.
  - start is ignored in every other state.
- WAIT:
  - data_ready=1, cpu_hold=1.
  - On data_valid=1, capture byte and last flag, then -> ADDR.
  - Otherwise stay; no timeout.
- ADDR: bus_oe=1, bus_out = zero-extended addr, nLma=0 for exactly one cycle -> DATA.
- DATA: bus_oe=1, bus_out = captured byte, nLmd=0 for one cycle -> WRITE.
- WRITE:
  - nCE=0 for one cycle, bus_oe=0; byte_count += 1.
  - If the captured last flag is set, or addr == RAM_BYTES-1 -> FIN.
  - Otherwise addr += 1 -> WAIT.
- FIN: done=1 for one cycle, cpu_hold=0 -> IDLE.
- cpu_hold=1 in WAIT, ADDR, DATA and WRITE.
- busy=1 in every state except IDLE.
- Strobes are mutually exclusive; at most one of nLma/nLmd/nCE is low in any cycle.
- bus_oe is high only in ADDR and DATA.
- Throughput: 4 cycles per byte with data_valid held high (accept, ADDR, DATA, WRITE).
- Accept-to-RAM-write latency: 3 cycles.
- Handshake: a byte transfers only on a cycle with data_valid && data_ready. data_ready is combinationally 0 outside WAIT. The source must hold data_in stable until the transfer.
- Address wrap: there is none. The 16th byte forces FIN even without data_last; further valid data is not accepted until the next start.
- data_last on the first byte gives a 1-byte load with byte_count=1.
- start and data_valid in the same IDLE cycle: only start takes effect; the byte is not accepted.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: checksum accumulates the 8-bit modulo-256 sum of every accepted byte, updated on the accept cycle. It is cleared on start, held after FIN until the next start, and reset to 0 by rst.
- Not defined: checksum is tied to 0 and no accumulator is instantiated.

Test Plan:
- Reset state: rst=1 for 2 cycles -> all strobes 1, bus_oe=0, cpu_hold=0, busy=0, byte_count=0.
- Three-byte load: start, then bytes 0x1A, 0x2B, 0x3C with data_last on 0x3C and data_valid held high.
  - Strobe order for each byte is nLma -> nLmd -> nCE.
  - bus_out shows 0x00/0x1A, 0x01/0x2B, 0x02/0x3C.
  - done pulses 13 cycles after start; byte_count=3.
  - With LOADER_CHECKSUM_EN, checksum=0x81.
- Full image: 16 bytes 0x00..0x0F with no data_last -> FIN after the write to address 0x0F, byte_count=16. A 17th valid byte is not accepted (data_ready=0).
- Backpressure: data_valid low for 5 cycles in WAIT -> stays in WAIT, data_ready=1, no strobes. Raising data_valid with 0x55 -> ADDR on the next edge.
- Reset mid-operation: rst=1 during DATA -> next cycle IDLE, nLmd=1, bus_oe=0, cpu_hold=0, no nCE pulse.
- Ignored start: start pulsed while in WAIT -> addr and byte_count unchanged, load continues normally.
